babbage_cube_root: RTL and testbench

BABBAGE_CUBE_ROOT -- requirements
Module: babbage_cube_root

---
 rtl/babbage_cube_root.sv | 106 ++++++++++
 tb/tb_babbage_cube_root.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/babbage_cube_root.sv
// Integer cube root by Babbage's method of differences: n^3 is built up by
// adding first and second differences until the next cube would pass the operand.
module babbage_cube_root (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iSTART,
  input  logic [17:0] iX,
  output logic        oREADY,
  output logic        oDONE,
  output logic [5:0]  oN,
  output logic        oEXACT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] x_q, x_d;
  logic [5:0]  n_q, n_d;
  logic [18:0] c_q, c_d;
  logic [18:0] d_q, d_d;
  logic [18:0] e_q, e_d;
  logic [5:0]  resN_q, resN_d;
  logic        exact_q, exact_d;

  logic [18:0] nextCube;
  logic        overshoot;

  // c+d is the cube of n+1; it never exceeds 64^3, so 19 bits hold it exactly
  assign nextCube  = c_q + d_q;
  assign overshoot = nextCube > {1'b0, x_q};

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      resN_q  <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      resN_q  <= resN_d;
      exact_q <= exact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    c_d     = c_q;
    d_d     = d_q;
    e_d     = e_q;
    resN_d  = resN_q;
    exact_d = exact_q;
    oREADY  = 1'b0;
    oDONE   = 1'b0;

    case (state_q)
      IDLE: begin
        oREADY = 1'b1;
        if (iSTART) begin
          x_d     = iX;
          n_d     = 6'd0;
          c_d     = 19'd0;
          d_d     = 19'd1;
          e_d     = 19'd6;
          state_d = CALC;
        end
      end
      CALC: begin
        if (overshoot) begin
          // Result is latched once here so it stays put through idle
          resN_d  = n_q;
          exact_d = (c_q == {1'b0, x_q});
          state_d = DONE;
        end else begin
          c_d = nextCube;
          d_d = d_q + e_q;
          e_d = e_q + 19'd6;
          n_d = n_q + 6'd1;
        end
      end
      DONE: begin
        oDONE   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oN     = resN_q;
  assign oEXACT = exact_q;

endmodule

// File: tb/tb_babbage_cube_root.sv
// Randomized and boundary checks of babbage_cube_root against a plain
// floor-cube-root model, including latency, start masking and mid-calc reset.
module tb_babbage_cube_root;

  logic        clk;
  logic        reset;
  logic        start;
  logic [17:0] x;
  logic        ready;
  logic        done;
  logic [5:0]  n;
  logic        exact;

  int checkCount = 0;
  int errorCount = 0;

  babbage_cube_root dut (
    .iCLK   (clk),
    .iRESET (reset),
    .iSTART (start),
    .iX     (x),
    .oREADY (ready),
    .oDONE  (done),
    .oN     (n),
    .oEXACT (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Floor cube root by direct search over candidate roots
  function automatic void refRoot(input int value, output int root, output int isExact);
    root = 0;
    while ((root + 1) * (root + 1) * (root + 1) <= value) root++;
    isExact = (root * root * root == value) ? 1 : 0;
  endfunction

  // Start one operation and check latency, result and the return to idle.
  // With disturb set, iSTART toggles and iX is set to 8 while the block is busy.
  task automatic applyStimulus(input int value, input bit disturb);
    int  expRoot, expExact, edges;
    bit  seen;
    refRoot(value, expRoot, expExact);
    @(negedge clk);
    start = 1'b1;
    x     = value[17:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = disturb ? 18'd8 : 18'($urandom);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else if (disturb) begin
        start = 1'($urandom);
      end
    end
    start = 1'b0;
    checkOutput($sformatf("doneSeen x=%0d", value), int'(seen), 1);
    if (seen) begin
      checkOutput($sformatf("latency x=%0d", value), edges, expRoot + 1);
      checkOutput($sformatf("root x=%0d", value), int'(n), expRoot);
      checkOutput($sformatf("exact x=%0d", value), int'(exact), expExact);
      checkOutput($sformatf("readyInDone x=%0d", value), int'(ready), 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("donePulse x=%0d", value), int'(done), 0);
      checkOutput($sformatf("readyAfter x=%0d", value), int'(ready), 1);
      checkOutput($sformatf("rootHeld x=%0d", value), int'(n), expRoot);
    end
  endtask

  initial begin
    int doneCount;
    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("resetReady", int'(ready), 1);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetRoot", int'(n), 0);
    checkOutput("resetExact", int'(exact), 0);

    // Directed corner cases
    applyStimulus(0, 1'b0);
    applyStimulus(27, 1'b0);
    applyStimulus(26, 1'b0);
    applyStimulus(262143, 1'b0);
    applyStimulus(250047, 1'b0);
    applyStimulus(1000, 1'b1);

    // Abort mid-calc: no result may escape for the aborted operation
    @(negedge clk);
    start = 1'b1;
    x     = 18'd125000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abortReady", int'(ready), 1);
    checkOutput("abortRoot", int'(n), 0);
    checkOutput("abortDone", int'(done), 0);
    doneCount = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("abortNoDone", doneCount, 0);
    applyStimulus(8, 1'b0);

    // Every perfect cube and its neighbours
    for (int k = 0; k < 64; k++) begin
      applyStimulus(k * k * k, 1'b0);
      if (k > 0) applyStimulus(k * k * k - 1, 1'b0);
    end
    applyStimulus(63 * 63 * 63 + 1, 1'b0);

    // Random operands, some with disturbance during calc
    for (int i = 0; i < 200; i++) begin
      applyStimulus(int'($urandom_range(262143, 0)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
